// File: rtl/dqs_eye_train_ctrl.sv
// ---------------------------------------------------------------------------
// dqs_eye_train_ctrl
//   Per-lane DQS read-window training controller. Sweeps the IOD RX delay
//   line upward from tap 0, samples the eye-monitor EARLY/LATE flags at every
//   tap, accepts the first clean run of at least MIN_WINDOW taps and then
//   walks the delay line back down to the centre of that run.
//
// Ports
//   FAB_CLK, ARST_N            clock / asynchronous active-low reset
//   START                      one-cycle pulse, starts training when not busy
//   EYE_MONITOR_EARLY/LATE     eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE    end-of-range indication from the IOD
//   DELAY_LINE_LOAD            pulse: reset the IOD delay line to tap 0
//   DELAY_LINE_MOVE            pulse: move the delay line one tap
//   DELAY_LINE_DIRECTION       1 = increment, 0 = decrement (held between moves)
//   EYE_MONITOR_CLEAR_FLAGS    pulse: clear the eye-monitor flags
//   BUSY / DONE / ERROR        training status (DONE/ERROR held until START)
//   FINAL_TAP                  parked tap, valid with DONE
//   WIN_LEFT / WIN_RIGHT       accepted window edges, valid with DONE
// ---------------------------------------------------------------------------
module dqs_eye_train_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_WINDOW    = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [TAP_W-1:0] FINAL_TAP,
    output logic [TAP_W-1:0] WIN_LEFT,
    output logic [TAP_W-1:0] WIN_RIGHT
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W:0]   MIN_W     = (TAP_W+1)'(MIN_WINDOW);
    localparam logic [CNT_W-1:0] SETTLE_LST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LST = CNT_W'(SAMPLE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
        S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
    } state_t;

    state_t state_q, state_d;

    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] left_q, left_d;
    logic [TAP_W-1:0] right_q, right_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic             found_left_q, found_left_d;
    logic             flag_q, flag_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             load_q, load_d;
    logic             move_q, move_d;
    logic             dir_q, dir_d;
    logic             clr_q, clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [TAP_W-1:0] final_tap_q, final_tap_d;
    logic [TAP_W-1:0] win_left_q, win_left_d;
    logic [TAP_W-1:0] win_right_q, win_right_d;

    // EVAL scratch values
    logic             end_c;
    logic             fl_v;
    logic             wchk;
    logic [TAP_W-1:0] l_v, r_v;
    logic [TAP_W:0]   width_v, sum_v;
    logic             cpulse;

    // ---------------- state / datapath registers ----------------
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            target_q     <= '0;
            found_left_q <= 1'b0;
            flag_q       <= 1'b0;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            left_q       <= left_d;
            right_q      <= right_d;
            target_q     <= target_d;
            found_left_q <= found_left_d;
            flag_q       <= flag_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
        end
    end

    // ---------------- next state + datapath ----------------
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        left_d       = left_q;
        right_d      = right_q;
        target_d     = target_q;
        found_left_d = found_left_q;
        flag_d       = flag_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        cpulse       = 1'b0;
        end_c        = (tap_q == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE;
        fl_v         = found_left_q;
        wchk         = 1'b0;
        l_v          = left_q;
        r_v          = right_q;
        width_v      = '0;
        sum_v        = '0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) state_d = S_LOAD;
            end
            S_LOAD: begin
                tap_d        = '0;
                found_left_d = 1'b0;
                state_d      = S_CLEAR;
            end
            S_CLEAR: begin
                flag_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                flag_d = flag_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
                if (cnt_q == SAMPLE_LST) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                // Rules are applied in order; a left edge opened at the last
                // tap is immediately closed by the end-of-sweep rule.
                if (!fl_v && !flag_q) begin
                    l_v  = tap_q;
                    fl_v = 1'b1;
                end else if (fl_v && flag_q) begin
                    r_v  = tap_q - TAP_W'(1);
                    wchk = 1'b1;
                end
                if (end_c && fl_v && !flag_q) begin
                    r_v  = tap_q;
                    wchk = 1'b1;
                end
                width_v = {1'b0, r_v} - {1'b0, l_v} + (TAP_W+1)'(1);
                sum_v   = {1'b0, l_v} + {1'b0, r_v};
                if (wchk && width_v >= MIN_W) begin
                    state_d = S_CENTER;
                end else begin
                    // narrow window: forget the left edge, keep sweeping
                    if (wchk) fl_v = 1'b0;
                    state_d = end_c ? S_FAIL : S_STEP;
                end
                left_d       = l_v;
                right_d      = r_v;
                found_left_d = fl_v;
                target_d     = TAP_W'(sum_v >> 1);
                phase_d      = 1'b0;
            end
            S_STEP: begin
                if (tap_q != LAST_TAP) tap_d = tap_q + TAP_W'(1);
                state_d = S_CLEAR;
            end
            S_CENTER: begin
                // Decrement pulses are spaced by one idle cycle.
                if (tap_q == target_q) begin
                    state_d = S_DONE;
                end else if (!phase_q) begin
                    tap_d   = tap_q - TAP_W'(1);
                    phase_d = 1'b1;
                    cpulse  = 1'b1;
                end else begin
                    phase_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registered outputs ----------------
    always_comb begin
        load_d      = (state_d == S_LOAD);
        clr_d       = (state_d == S_CLEAR);
        move_d      = (state_d == S_STEP) || cpulse;
        dir_d       = dir_q;
        if (state_d == S_STEP) dir_d = 1'b1;
        else if (cpulse)       dir_d = 1'b0;
        busy_d      = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_FAIL);
        final_tap_d = final_tap_q;
        win_left_d  = win_left_q;
        win_right_d = win_right_q;
        if (state_d == S_DONE) begin
            final_tap_d = tap_d;
            win_left_d  = left_d;
            win_right_d = right_d;
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            dir_q       <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            final_tap_q <= '0;
            win_left_q  <= '0;
            win_right_q <= '0;
        end else begin
            load_q      <= load_d;
            move_q      <= move_d;
            dir_q       <= dir_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            final_tap_q <= final_tap_d;
            win_left_q  <= win_left_d;
            win_right_q <= win_right_d;
        end
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign ERROR                   = error_q;
    assign FINAL_TAP               = final_tap_q;
    assign WIN_LEFT                = win_left_q;
    assign WIN_RIGHT               = win_right_q;

endmodule

// File: tb/tb_dqs_eye_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dqs_eye_train_ctrl
//   Directed bench. A small IOD model tracks the delay-line tap from the
//   LOAD/MOVE pulses and drives EARLY/LATE/OUT_OF_RANGE from a per-test eye
//   pattern. Expected window edges, parked taps and pulse counts are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dqs_eye_train_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic       START;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;
    logic [6:0] FINAL_TAP;
    logic [6:0] WIN_LEFT;
    logic [6:0] WIN_RIGHT;

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int oor_at = 1000;
    int iod_tap = 0;
    int inc_cnt = 0;
    int dec_cnt = 0;
    int ovl_cnt = 0;
    int i0, d0;

    always #5 FAB_CLK = ~FAB_CLK;

    dqs_eye_train_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .START                   (START),
        .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .BUSY                    (BUSY),
        .DONE                    (DONE),
        .ERROR                   (ERROR),
        .FINAL_TAP               (FINAL_TAP),
        .WIN_LEFT                (WIN_LEFT),
        .WIN_RIGHT               (WIN_RIGHT)
    );

    // Eye patterns (1 = flags raised at that tap)
    //   0: dirty 0-9 and 30+      1: clean only 5-6 and 20-40 (on LATE)
    //   2: never clean            3: clean from 120 to the end
    assign EYE_MONITOR_EARLY = (mode == 0 && (iod_tap < 10 || iod_tap >= 30)) ||
                               (mode == 2) ||
                               (mode == 3 && iod_tap < 120);
    assign EYE_MONITOR_LATE  = (mode == 1) &&
                               !((iod_tap >= 5 && iod_tap <= 6) || (iod_tap >= 20 && iod_tap <= 40));
    assign DELAY_LINE_OUT_OF_RANGE = (iod_tap >= oor_at);

    // IOD delay-line model and pulse counters
    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) iod_tap <= 0;
        if (DELAY_LINE_MOVE) begin
            if (DELAY_LINE_DIRECTION) begin
                iod_tap <= iod_tap + 1;
                inc_cnt <= inc_cnt + 1;
            end else begin
                iod_tap <= iod_tap - 1;
                dec_cnt <= dec_cnt + 1;
            end
        end
        if (DELAY_LINE_LOAD && DELAY_LINE_MOVE) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // START high for exactly one rising edge; returns at the following negedge+1
    task automatic start_pulse();
        i0 = inc_cnt;
        d0 = dec_cnt;
        START = 1'b1;
        @(negedge FAB_CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 6000; i++) begin
            @(negedge FAB_CLK); #1;
            if (DONE || ERROR) break;
        end
        chk("end_reached", 32'(DONE | ERROR), 32'd1);
    endtask

    initial begin
        ARST_N = 1'b1;
        START  = 1'b0;
        #2 ARST_N = 1'b0;
        #1;
        chk("rst_ctl", 32'({BUSY, DONE, ERROR, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                             DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}), 32'd0);
        chk("rst_taps", 32'({FINAL_TAP, WIN_LEFT, WIN_RIGHT}), 32'd0);
        repeat (2) @(negedge FAB_CLK);
        #1 ARST_N = 1'b1;
        @(negedge FAB_CLK); #1;
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Basic window 10..29
        mode = 0;
        start_pulse();
        chk("t1_load", 32'(DELAY_LINE_LOAD), 32'd1);
        chk("t1_busy", 32'(BUSY), 32'd1);
        wait_end();
        chk("t1_done",  32'(DONE), 32'd1);
        chk("t1_err",   32'(ERROR), 32'd0);
        chk("t1_busy0", 32'(BUSY), 32'd0);
        chk("t1_left",  32'(WIN_LEFT), 32'd10);
        chk("t1_right", 32'(WIN_RIGHT), 32'd29);
        chk("t1_final", 32'(FINAL_TAP), 32'd19);
        chk("t1_inc",   inc_cnt - i0, 32'd30);
        chk("t1_dec",   dec_cnt - d0, 32'd11);
        chk("t1_iod",   iod_tap, 32'd19);

        // Restart from DONE; glitch window rejected; START while busy ignored
        mode = 1;
        start_pulse();
        chk("t2_done_clr", 32'(DONE), 32'd0);
        chk("t2_load",     32'(DELAY_LINE_LOAD), 32'd1);
        repeat (100) @(negedge FAB_CLK);
        #1 START = 1'b1;
        @(negedge FAB_CLK);
        #1 START = 1'b0;
        wait_end();
        chk("t2_done",  32'(DONE), 32'd1);
        chk("t2_left",  32'(WIN_LEFT), 32'd20);
        chk("t2_right", 32'(WIN_RIGHT), 32'd40);
        chk("t2_final", 32'(FINAL_TAP), 32'd30);
        chk("t2_inc",   inc_cnt - i0, 32'd41);
        chk("t2_dec",   dec_cnt - d0, 32'd11);

        // No clean tap anywhere
        mode = 2;
        start_pulse();
        wait_end();
        chk("t3_err",   32'(ERROR), 32'd1);
        chk("t3_done",  32'(DONE), 32'd0);
        chk("t3_busy",  32'(BUSY), 32'd0);
        chk("t3_final", 32'(FINAL_TAP), 32'd30);
        chk("t3_inc",   inc_cnt - i0, 32'd127);
        chk("t3_dec",   dec_cnt - d0, 32'd0);

        // Clean to the last tap (restart from FAIL)
        mode = 3;
        start_pulse();
        chk("t4_err_clr", 32'(ERROR), 32'd0);
        wait_end();
        chk("t4_done",  32'(DONE), 32'd1);
        chk("t4_left",  32'(WIN_LEFT), 32'd120);
        chk("t4_right", 32'(WIN_RIGHT), 32'd127);
        chk("t4_final", 32'(FINAL_TAP), 32'd123);
        chk("t4_inc",   inc_cnt - i0, 32'd127);
        chk("t4_dec",   dec_cnt - d0, 32'd4);

        // Same, out-of-range at tap 125
        oor_at = 125;
        start_pulse();
        wait_end();
        chk("t5_done",  32'(DONE), 32'd1);
        chk("t5_left",  32'(WIN_LEFT), 32'd120);
        chk("t5_right", 32'(WIN_RIGHT), 32'd125);
        chk("t5_final", 32'(FINAL_TAP), 32'd122);
        chk("t5_inc",   inc_cnt - i0, 32'd125);
        chk("t5_dec",   dec_cnt - d0, 32'd3);
        oor_at = 1000;

        // Reset during SAMPLE at tap 15
        mode = 0;
        start_pulse();
        for (int i = 0; i < 3000; i++) begin
            @(negedge FAB_CLK); #1;
            if (iod_tap == 15) break;
        end
        chk("t6_reach15", iod_tap, 32'd15);
        repeat (12) @(negedge FAB_CLK);
        #1 ARST_N = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({BUSY, DONE, ERROR, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                                DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}), 32'd0);
        chk("t6_rst_taps", 32'({FINAL_TAP, WIN_LEFT, WIN_RIGHT}), 32'd0);
        repeat (2) @(negedge FAB_CLK);
        #1 ARST_N = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        #1;
        chk("t6_idle", 32'({BUSY, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}), 32'd0);
        start_pulse();
        chk("t6_load", 32'(DELAY_LINE_LOAD), 32'd1);
        wait_end();
        chk("t6_done",  32'(DONE), 32'd1);
        chk("t6_final", 32'(FINAL_TAP), 32'd19);
        chk("t6_inc",   inc_cnt - i0, 32'd30);

        chk("load_move_overlap", ovl_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
